uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart to the team's UART transmitter, consuming the 8N1-style serial line it produces. It oversamples the line with a counter running on the system clock, with no derived clock. It validates start and stop bits, shifts in data LSB first, and presents each received word through a one-entry valid/ready output buffer. Framing and overrun conditions are reported as status pulses.

## Interface
- SYS_CLK_FREQ, default 10**6: system clock frequency in Hz.
- BAUD_RATE, default 9600: line rate in bit/s.
- DATA_WIDTH, default 8: data bits per frame.
- Derived constants:
  - CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE, integer division, default 104; must be >= 4.
  - HALF_BIT = CLKS_PER_BIT / 2, default 52.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- areset_n  input  1  reset, asynchronous and active-low.
- data_in  input  1  serial line; idles high; asynchronous to sys_clk.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  DATA_WIDTH  received word, valid while data_valid = 1.
- data_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  frame reception in progress (state != IDLE).
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.

## Operation
- Synchronizer: rx_meta <= data_in, then rx_sync <= rx_meta. Both reset to 1. The FSM uses only rx_sync.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). bit_idx has width $clog2(DATA_WIDTH)+1.
- States:
  - IDLE: if rx_sync == 0, go to START with cnt <= 0.
  - START: cnt increments each cycle. At cnt == HALF_BIT-1, sample rx_sync:
    - 0: go to DATA with cnt <= 0 and bit_idx <= 0.
    - 1: glitch; return to IDLE with no other effect.
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At cnt == CLKS_PER_BIT-1:
    - shift_reg[bit_idx] <= rx_sync, bit_idx++, cnt <= 0.
    - After bit DATA_WIDTH-1, go to STOP.
  - STOP: at cnt == CLKS_PER_BIT-1, sample rx_sync:
    - 1: commit the word (see Output buffer), then go to IDLE.
    - 0: framing_error pulse, word discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_sync == 1, then go to IDLE. This prevents a break or stuck-low line from being re-detected as start bits.
- Output buffer:
  - Transfer occurs on any edge where data_valid && data_ready. data_valid then clears unless a commit happens on the same edge.
  - Commit when the buffer is empty, or being consumed on the same edge: data_out <= shift_reg, data_valid <= 1.
  - Commit when the buffer is full and data_ready = 0: the new word is dropped, overrun pulses, and data_out/data_valid are unchanged.
  - data_out is stable while data_valid = 1 and no transfer has occurred.
- Asynchronous reset mid-frame: everything returns to reset values immediately and any partial word is lost. Reception resumes on the next start bit after release.

## Timing
- Reset values:
  - data_out = 0, data_valid = 0, busy = 0, framing_error = 0, overrun = 0.
  - State IDLE, cnt = 0, bit_idx = 0, rx_meta = rx_sync = 1.
- Reference edge E0: the first sys_clk edge that captures data_in = 0.
  - rx_sync = 0 after E1.
  - IDLE -> START on E2; busy high from E2.
  - Start bit checked at E2+HALF_BIT.
  - Data bit k sampled at E2+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit sampled at E2+HALF_BIT+(DATA_WIDTH+1)*CLKS_PER_BIT. data_valid and framing_error/overrun are asserted after this edge, and busy drops after it (IDLE) on a good stop bit.
- Defaults: data_valid high after edge E0+990, i.e. 2+52+9*104.
- Next-frame detection: a new start bit whose falling edge falls within half a bit period after the stop bit is detected normally, with no dead time beyond the synchronizer.
- framing_error and overrun are high for exactly one cycle per event.

## Test plan
- Hold data_in = 1 and assert areset_n mid-frame (after bit 3 of a 0x5A frame) -> all outputs 0 immediately. A subsequent full 0x5A frame is received correctly.
- Frame 0xA5 at 104 cycles/bit with stop = 1 and data_ready = 1 -> data_valid high one cycle at E0+990, data_out = 0xA5, busy = 0 afterwards, no flags.
- data_in low for 10 cycles, then high -> no data_valid and no flags; busy high E2..E2+52, then 0.
- Frame 0x3C with stop bit 0 and line held low for 3 more bit times -> framing_error single pulse at the stop sample, no data_valid, busy stays 1 until 2 cycles after the line returns high.
- data_ready = 0, frames 0x11 then 0x22 -> data_out = 0x11 held valid, overrun pulse at the 0x22 stop sample. Then data_ready = 1 for one cycle -> 0x11 transferred, data_valid = 0.
- Back-to-back frames 0x00, 0xFF, 0x80 with no idle gap and data_ready = 1 -> three data_valid pulses spaced 10*104 = 1040 cycles apart, values in order, no flags.

Source files
------------

// File: rtl/uart_rx.sv
// Purpose     : 8N1-style UART receiver, oversampled on sys_clk, with a one-entry valid/ready output buffer.
// Latency     : word is valid 2 + HALF_BIT + DATA_WIDTH*CLKS_PER_BIT + CLKS_PER_BIT edges after the start bit is first captured.
// Backpressure: a word completed while the buffer is full and data_ready is low is dropped and reported on overrun.
//
// Ports:
//   sys_clk       system clock, all logic on its rising edge
//   areset_n      asynchronous active-low reset
//   data_in       serial line, idles high, asynchronous to sys_clk
//   data_ready    downstream accepts data_out this cycle
//   data_out      received word, meaningful while data_valid = 1
//   data_valid    data_out holds an unconsumed word
//   busy          frame reception in progress
//   framing_error one-cycle pulse, stop bit sampled low
//   overrun       one-cycle pulse, completed word dropped (buffer full)
//
// CLKS_PER_BIT must be >= 4 and DATA_WIDTH >= 2.
module uart_rx #(
    parameter int SYS_CLK_FREQ = 1_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  sys_clk,
    input  logic                  areset_n,
    input  logic                  data_in,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_busy;
    logic                  r_framing_error;
    logic                  r_overrun;

    logic                  w_xfer;

    assign w_xfer        = r_data_valid & data_ready;

    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;
    assign busy          = r_busy;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= data_in;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive FSM plus output buffer. Later non-blocking writes win, so a
    // commit on the same edge as a transfer keeps data_valid set.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;

            if (w_xfer) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the line mid start bit to reject glitches.
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Sampling is now aligned to the middle of each bit cell.
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt                       <= '0;
                        r_shift[r_bit_idx[IDX_W-2:0]] <= r_rx_sync;
                        r_bit_idx                   <= r_bit_idx + 1'b1;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Returning to IDLE at mid stop bit leaves half a bit of
                // margin to catch a back-to-back start bit.
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_sync) begin
                            if (!r_data_valid || data_ready) begin
                                r_data_out   <= r_shift;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_framing_error <= 1'b1;
                            r_state         <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A break or stuck-low line must not look like new start bits.
                S_WAIT_HIGH: begin
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at default parameters (104 clocks per bit).
// Stimulus pushes expected words into a scoreboard queue; a negedge monitor
// pops and compares on every transfer and tallies status pulses.
module tb_uart_rx;

    localparam int CPB   = 104;
    localparam int HALF  = 52;
    localparam int FRAME = 10 * CPB;
    localparam int LAT   = 2 + HALF + 9 * CPB;   // 990

    logic       sys_clk = 1'b0;
    logic       areset_n;
    logic       data_in;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    uart_rx #(
        .SYS_CLK_FREQ(1_000_000),
        .BAUD_RATE   (9600),
        .DATA_WIDTH  (8)
    ) dut (
        .sys_clk      (sys_clk),
        .areset_n     (areset_n),
        .data_in      (data_in),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    int         vhi_cnt = 0;
    int         fe_cyc  = -1;
    int         ov_cyc  = -1;
    logic       valid_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: samples away from the active edge.
    always @(negedge sys_clk) begin
        if (areset_n === 1'b1) begin
            if (framing_error) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (data_valid) vhi_cnt++;
            if (data_valid && !valid_q) rise_q.push_back(cyc);
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, scoreboard empty", data_out);
                end else begin
                    check("data_out", int'(data_out), int'(exp_q.pop_front()));
                end
            end
        end
        valid_q = data_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        repeat (CPB) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Returns at the negedge following posedge number n.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    initial begin
        int         e0, h, r0, fe0, ov0, vh0;
        logic [7:0] d;

        areset_n   = 1'b0;
        data_in    = 1'b1;
        data_ready = 1'b1;
        repeat (3) sync();

        // Reset values
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_framing_error", int'(framing_error), 0);
        check("rst_overrun", int'(overrun), 0);
        areset_n = 1'b1;
        repeat (2) sync();

        // Async reset after bit 3 of a 0x5A frame, then a clean 0x5A
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        check("midframe_busy", int'(busy), 1);
        data_in = 1'b1;
        #2 areset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_data_valid", int'(data_valid), 0);
        check("midrst_data_out", int'(data_out), 0);
        repeat (3) sync();
        areset_n = 1'b1;
        repeat (2) sync();
        vh0 = vhi_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (4) sync();
        check("recover_drained", exp_q.size(), 0);
        check("recover_valid_cycles", vhi_cnt - vh0, 1);
        check("recover_no_fe", fe_cnt - fe0, 0);

        // Single 0xA5 frame, latency and flags
        r0 = rise_q.size(); vh0 = vhi_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        e0 = cyc + 1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (4) sync();
        check("a5_rise_count", rise_q.size() - r0, 1);
        check("a5_rise_cycle", rise_q[r0], e0 + LAT);
        check("a5_valid_cycles", vhi_cnt - vh0, 1);
        check("a5_busy_after", int'(busy), 0);
        check("a5_no_fe", fe_cnt - fe0, 0);
        check("a5_no_ov", ov_cnt - ov0, 0);

        // Ten-cycle glitch: rejected at mid start bit
        vh0 = vhi_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        e0 = cyc + 1;
        data_in = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1 data_in = 1'b1;
        wait_cyc(e0 + 9);
        check("glitch_busy_early", int'(busy), 1);
        wait_cyc(e0 + 2 + HALF - 1);
        check("glitch_busy_last", int'(busy), 1);
        wait_cyc(e0 + 2 + HALF);
        check("glitch_busy_drop", int'(busy), 0);
        sync();
        repeat (200) sync();
        check("glitch_no_valid", vhi_cnt - vh0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);

        // 0x3C with low stop bit, line held low three more bit times
        vh0 = vhi_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        e0 = cyc + 1;
        send_frame(8'h3C, 1'b0);
        repeat (3) send_bit(1'b0);
        h = cyc;
        data_in = 1'b1;
        wait_cyc(h + 2);
        check("fe_busy_hold", int'(busy), 1);
        wait_cyc(h + 3);
        check("fe_busy_drop", int'(busy), 0);
        sync();
        check("fe_pulse_cycles", fe_cnt - fe0, 1);
        check("fe_pulse_cycle", fe_cyc, e0 + LAT);
        check("fe_no_valid", vhi_cnt - vh0, 0);
        check("fe_no_ov", ov_cnt - ov0, 0);

        // Overrun: 0x11 then 0x22 with data_ready low
        data_ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        e0 = cyc + 1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) sync();
        check("ov_pulse_cycles", ov_cnt - ov0, 1);
        check("ov_pulse_cycle", ov_cyc, e0 + FRAME + LAT);
        check("ov_held_data", int'(data_out), 8'h11);
        check("ov_held_valid", int'(data_valid), 1);
        check("ov_no_fe", fe_cnt - fe0, 0);
        data_ready = 1'b1;
        sync();
        data_ready = 1'b0;
        check("ov_valid_cleared", int'(data_valid), 0);
        check("ov_drained", exp_q.size(), 0);

        // Back-to-back 0x00, 0xFF, 0x80
        data_ready = 1'b1;
        r0 = rise_q.size(); vh0 = vhi_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        e0 = cyc + 1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        repeat (4) sync();
        check("b2b_rise_count", rise_q.size() - r0, 3);
        check("b2b_first_cycle", rise_q[r0], e0 + LAT);
        check("b2b_spacing_1", rise_q[r0 + 1] - rise_q[r0], FRAME);
        check("b2b_spacing_2", rise_q[r0 + 2] - rise_q[r0 + 1], FRAME);
        check("b2b_valid_cycles", vhi_cnt - vh0, 3);
        check("b2b_no_fe", fe_cnt - fe0, 0);
        check("b2b_no_ov", ov_cnt - ov0, 0);
        check("b2b_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
